// File: rtl/dmem_align_unit.sv
// Load/store alignment unit between the LSU and the D-cache: issues word-aligned
// cache transactions with lane masks, splits word-crossing accesses, and extends load data.
module dmem_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int XLEN             = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            req_ready,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_pte,
  output logic            resp_valid,
  output logic            resp_error,
  output logic            resp_errty,
  output logic [XLEN-1:0] resp_rdata,
  input  logic            creq_ready,
  output logic            creq_valid,
  output logic [XLEN-1:0] creq_addr,
  output logic            creq_wen,
  output logic [XLEN-1:0] creq_wdata,
  output logic [3:0]      creq_wmask,
  output logic [1:0]      creq_pte,
  input  logic            cresp_valid,
  input  logic            cresp_error,
  input  logic            cresp_errty,
  input  logic [XLEN-1:0] cresp_rdata
);

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_D = 2'd3;
  localparam logic FE_PAGE_FAULT   = 1'b0;
  localparam logic FE_ACCESS_FAULT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wdata_r;
  logic [XLEN-1:0] lo_r;
  logic [1:0]      size_r;
  logic            signed_r;
  logic            wen_r;

  logic [1:0]      src_off_s;
  logic [1:0]      src_size_s;
  logic [XLEN-1:0] src_wdata_s;
  logic [7:0]      mask8_s;
  logic [63:0]     lanes_s;
  logic            cross_s;
  logic            misalign_fault_s;

  function automatic logic [3:0] size_byte_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic naturally_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b1;
      SIZE_H:  return (off[0] == 1'b0);
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] off, input logic [1:0] size,
                                              input logic sgn);
    logic [63:0] shifted;
    shifted = {hi, lo} >> {off, 3'b000};
    case (size)
      SIZE_B:  return {{24{sgn & shifted[7]}}, shifted[7:0]};
      SIZE_H:  return {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: return shifted[31:0];
    endcase
  endfunction

  // Lane geometry: taken from the live request while idle, from the latched copy afterwards.
  always_comb begin
    src_off_s   = addr_r[1:0];
    src_size_s  = size_r;
    src_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      src_off_s   = req_addr[1:0];
      src_size_s  = req_size;
      src_wdata_s = req_wdata;
    end else begin
      src_off_s   = addr_r[1:0];
      src_size_s  = size_r;
      src_wdata_s = wdata_r;
    end
    mask8_s          = {4'b0000, size_byte_mask(src_size_s)} << src_off_s;
    lanes_s          = {32'd0, src_wdata_s} << {src_off_s, 3'b000};
    cross_s          = (mask8_s[7:4] != 4'b0000);
    misalign_fault_s = (ALLOW_MISALIGNED == 1'b0) && !naturally_aligned(src_size_s, src_off_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_errty <= 1'b0;
      resp_rdata <= 32'd0;
      creq_valid <= 1'b0;
      creq_addr  <= 32'd0;
      creq_wen   <= 1'b0;
      creq_wdata <= 32'd0;
      creq_wmask <= 4'b0000;
      creq_pte   <= 2'b00;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      lo_r       <= 32'd0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      wen_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            size_r    <= req_size;
            signed_r  <= req_signed;
            wen_r     <= req_wen;
            req_ready <= 1'b0;
            if ((req_size == SIZE_D) || misalign_fault_s) begin
              state_r    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_errty <= FE_ACCESS_FAULT;
              resp_rdata <= 32'd0;
            end else begin
              state_r    <= ST_REQ0;
              creq_valid <= 1'b1;
              creq_addr  <= {req_addr[31:2], 2'b00};
              creq_wen   <= req_wen;
              creq_wdata <= lanes_s[31:0];
              creq_wmask <= mask8_s[3:0];
              creq_pte   <= req_pte;
            end
          end
        end
        ST_REQ0: begin
          if (creq_ready) begin
            creq_valid <= 1'b0;
            state_r    <= ST_WAIT0;
          end
        end
        ST_WAIT0: begin
          if (cresp_valid) begin
            lo_r <= cresp_rdata;
            if (cresp_error) begin
              state_r    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_errty <= cresp_errty;
              resp_rdata <= 32'd0;
            end else if (cross_s) begin
              state_r    <= ST_REQ1;
              creq_valid <= 1'b1;
              creq_addr  <= creq_addr + 32'd4;
              creq_wdata <= lanes_s[63:32];
              creq_wmask <= mask8_s[7:4];
            end else begin
              state_r    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_errty <= FE_PAGE_FAULT;
              resp_rdata <= wen_r ? 32'd0
                                  : extend_load(cresp_rdata, 32'd0, addr_r[1:0], size_r, signed_r);
            end
          end
        end
        ST_REQ1: begin
          if (creq_ready) begin
            creq_valid <= 1'b0;
            state_r    <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          // A faulting second half still leaves the first store half committed.
          if (cresp_valid) begin
            state_r    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_error <= cresp_error;
            resp_errty <= cresp_error ? cresp_errty : FE_PAGE_FAULT;
            resp_rdata <= (wen_r || cresp_error) ? 32'd0
                          : extend_load(lo_r, cresp_rdata, addr_r[1:0], size_r, signed_r);
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          creq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
